// File: rtl/lcd_timing_ctrl.sv
// Runtime-reconfigurable raster generator: HS/VS/DE timing, pixel request coordinates,
// and a latency pipeline that keeps sync/DE aligned with the returned pixel data.
module lcd_timing_ctrl #(
    parameter int unsigned DATA_W  = 24,
    parameter int unsigned COORD_W = 12,
    parameter int unsigned LAT     = 2,
    parameter int unsigned H_ACT   = 1280,
    parameter int unsigned H_FP    = 110,
    parameter int unsigned H_SYNC  = 40,
    parameter int unsigned H_BP    = 220,
    parameter int unsigned V_ACT   = 720,
    parameter int unsigned V_FP    = 5,
    parameter int unsigned V_SYNC  = 5,
    parameter int unsigned V_BP    = 20,
    parameter bit          HS_POL  = 1'b1,
    parameter bit          VS_POL  = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_wr,
    input  logic [31:0]        cfg_data,
    output logic               cfg_pending,
    output logic               cfg_err,
    output logic               lcd_request,
    output logic [COORD_W-1:0] lcd_xpos,
    output logic [COORD_W-1:0] lcd_ypos,
    input  logic [DATA_W-1:0]  lcd_data,
    output logic               lcd_hs,
    output logic               lcd_vs,
    output logic               lcd_en,
    output logic [DATA_W-1:0]  lcd_rgb,
    output logic               frame_start
);

    localparam int unsigned TW = COORD_W + 2;
    localparam logic [TW-1:0] MAX_TOT = {2'b00, {COORD_W{1'b1}}};
    // Timing field order: H_ACT, H_FP, H_SYNC, H_BP, V_ACT, V_FP, V_SYNC, V_BP.
    localparam logic [COORD_W-1:0] RST_TIM [8] = '{
        COORD_W'(H_ACT), COORD_W'(H_FP), COORD_W'(H_SYNC), COORD_W'(H_BP),
        COORD_W'(V_ACT), COORD_W'(V_FP), COORD_W'(V_SYNC), COORD_W'(V_BP)
    };

    logic [COORD_W-1:0] act_q [8];
    logic [COORD_W-1:0] shd_q [8];
    logic [COORD_W-1:0] h_cnt_q, v_cnt_q;
    logic               en_q, pending_q, err_q;
    logic [3:0]         pipe_q [LAT+1];  // {fs, de, vs, hs}
    logic [DATA_W-1:0]  rgb_q;

    function automatic logic [TW-1:0] ext(input logic [COORD_W-1:0] x);
        return TW'(x);
    endfunction

    logic [TW-1:0] h_beg, h_end, h_tot, v_beg, v_end, v_tot, shd_h_tot, shd_v_tot;
    logic          h_last, v_last, h_in, v_in, hs_raw, vs_raw, fs_raw, de_lat, boundary;
    logic [3:0]         cmd_field;
    logic [COORD_W-1:0] cmd_val, cmd_fix;
    logic               commit, commit_ok, unused_cfg;

    assign h_beg     = ext(act_q[2]) + ext(act_q[3]);
    assign h_end     = h_beg + ext(act_q[0]);
    assign h_tot     = h_end + ext(act_q[1]);
    assign v_beg     = ext(act_q[6]) + ext(act_q[7]);
    assign v_end     = v_beg + ext(act_q[4]);
    assign v_tot     = v_end + ext(act_q[5]);
    assign shd_h_tot = ext(shd_q[0]) + ext(shd_q[1]) + ext(shd_q[2]) + ext(shd_q[3]);
    assign shd_v_tot = ext(shd_q[4]) + ext(shd_q[5]) + ext(shd_q[6]) + ext(shd_q[7]);

    assign h_last = ext(h_cnt_q) == h_tot - TW'(1);
    assign v_last = ext(v_cnt_q) == v_tot - TW'(1);
    assign h_in   = ext(h_cnt_q) >= h_beg && ext(h_cnt_q) < h_end;
    assign v_in   = ext(v_cnt_q) >= v_beg && ext(v_cnt_q) < v_end;

    assign lcd_request = en_q && h_in && v_in;
    assign lcd_xpos    = lcd_request ? COORD_W'(ext(h_cnt_q) - h_beg) : '0;
    assign lcd_ypos    = lcd_request ? COORD_W'(ext(v_cnt_q) - v_beg) : '0;
    assign hs_raw      = en_q && h_cnt_q < act_q[2];
    assign vs_raw      = en_q && v_cnt_q < act_q[6];
    assign fs_raw      = en_q && h_cnt_q == '0 && v_cnt_q == '0;

    assign cmd_field  = cfg_data[31:28];
    assign cmd_val    = cfg_data[COORD_W-1:0];
    assign cmd_fix    = (cmd_val == '0) ? COORD_W'(1) : cmd_val;
    assign unused_cfg = ^cfg_data[27:COORD_W];
    assign commit     = cfg_wr && cmd_field == 4'd8;
    assign commit_ok  = commit && shd_h_tot <= MAX_TOT && shd_v_tot <= MAX_TOT;
    // While stopped the counters sit at 0, so a pending update is taken immediately.
    assign boundary   = pending_q && (!en_q || (h_last && v_last));

    // DE as it stands when the matching lcd_data arrives, LAT cycles after the request.
    if (LAT == 0) begin : g_lat0
        assign de_lat = lcd_request;
    end else begin : g_latn
        assign de_lat = pipe_q[LAT-1][2];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            en_q      <= 1'b1;
            pending_q <= 1'b0;
            err_q     <= 1'b0;
            rgb_q     <= '0;
            for (int i = 0; i < 8; i++) begin
                act_q[i] <= RST_TIM[i];
                shd_q[i] <= RST_TIM[i];
            end
            for (int k = 0; k <= LAT; k++) pipe_q[k] <= '0;
        end else begin
            if (!en_q) begin
                h_cnt_q <= '0;
                v_cnt_q <= '0;
            end else if (h_last) begin
                h_cnt_q <= '0;
                v_cnt_q <= v_last ? '0 : v_cnt_q + COORD_W'(1);
            end else begin
                h_cnt_q <= h_cnt_q + COORD_W'(1);
            end

            if (boundary) begin
                for (int i = 0; i < 8; i++) act_q[i] <= shd_q[i];
                pending_q <= commit_ok;
            end else if (commit_ok) begin
                pending_q <= 1'b1;
            end
            if (cfg_wr && !cmd_field[3]) shd_q[cmd_field[2:0]] <= cmd_fix;
            if (cfg_wr && cmd_field == 4'd9) en_q <= cmd_val[0];
            err_q <= commit && !commit_ok;

            pipe_q[0] <= {fs_raw, lcd_request, vs_raw, hs_raw};
            for (int k = 1; k <= LAT; k++) pipe_q[k] <= pipe_q[k-1];
            rgb_q <= de_lat ? lcd_data : '0;
        end
    end

    assign cfg_pending = pending_q;
    assign cfg_err     = err_q;
    assign lcd_hs      = HS_POL ? pipe_q[LAT][0] : !pipe_q[LAT][0];
    assign lcd_vs      = VS_POL ? pipe_q[LAT][1] : !pipe_q[LAT][1];
    assign lcd_en      = pipe_q[LAT][2];
    assign frame_start = pipe_q[LAT][3];
    assign lcd_rgb     = rgb_q;

endmodule

// File: doc/lcd_timing_ctrl.md
# lcd_timing_ctrl

Parametrised, runtime-reconfigurable video timing controller that generates the HS/VS/DE raster and pixel request coordinates for the HDMI transmitter. It replaces the fixed-mode LCD driver. It adds:
- a command port that loads new timing values, applied only at a frame boundary;
- a run/stop enable;
- a configurable pixel-source latency, with sync/DE/RGB pipelined to match.

It sits between the pixel generator (`lcd_xpos`/`lcd_ypos` → `lcd_data`) and `hdmi_tx` in the pixel-clock domain.

## Interface
Parameters:
- `DATA_W`, 24: pixel width.
- `COORD_W`, 12: coordinate and counter width.
- `LAT`, 2: cycles from `lcd_xpos`/`lcd_ypos` to valid `lcd_data` (0..8).
- `H_ACT` 1280, `H_FP` 110, `H_SYNC` 40, `H_BP` 220: reset horizontal timing.
- `V_ACT` 720, `V_FP` 5, `V_SYNC` 5, `V_BP` 20: reset vertical timing.
- `HS_POL` 1, `VS_POL` 1: active level of HS/VS.

Ports:
- `clk`  in  1  pixel clock. One clock domain; reset is synchronous and active-high.
- `rst`  in  1  synchronous active-high reset.
- `cfg_wr`  in  1  one-cycle command strobe.
- `cfg_data`  in  32  command: [31:28] field, [COORD_W-1:0] value.
- `cfg_pending`  out  1  a commit is waiting for the frame boundary.
- `cfg_err`  out  1  one-cycle pulse when a commit is rejected.
- `lcd_request`  out  1  current coordinate is active; `lcd_data` is required LAT cycles later.
- `lcd_xpos`, `lcd_ypos`  out  COORD_W  active-area coordinates (0 when not requesting).
- `lcd_data`  in  DATA_W  pixel for the coordinate issued LAT cycles earlier.
- `lcd_hs`, `lcd_vs`, `lcd_en`  out  1  sync and data-enable, aligned to `lcd_rgb`.
- `lcd_rgb`  out  DATA_W  pixel; 0 when `lcd_en`=0.
- `frame_start`  out  1  one-cycle pulse aligned with the first `lcd_hs` cycle of the frame.

## Operation
- Counters `h_cnt` run 0..H_TOT-1 and `v_cnt` run 0..V_TOT-1.
  - H_TOT = H_SYNC+H_BP+H_ACT+H_FP; V_TOT likewise.
  - `v_cnt` increments when `h_cnt` wraps.
- Region order in each axis: sync, back porch, active, front porch.
  - HS active for h_cnt < H_SYNC; VS active for v_cnt < V_SYNC.
  - Active when H_SYNC+H_BP ≤ h_cnt < H_SYNC+H_BP+H_ACT, and likewise for v.
- `lcd_request`, `lcd_xpos` = h_cnt−(H_SYNC+H_BP), and `lcd_ypos` are combinational from the counters.
- The HS/VS/DE/frame_start timing bits pass through LAT+1 register stages.
- `lcd_rgb` is registered: `lcd_data` is sampled when the delayed DE is true, otherwise 0.
- Commands, by field:
  - 0..7: write shadow H_ACT, H_FP, H_SYNC, H_BP, V_ACT, V_FP, V_SYNC, V_BP. A value of 0 is stored as 1.
  - 8: commit.
  - 9: enable = value[0].
  - 10..15: ignored.
- Commit: if shadow H_TOT or V_TOT > 2^COORD_W−1, pulse `cfg_err` and leave pending unchanged. Otherwise set pending.
- Boundary is the cycle with h_cnt=H_TOT−1 and v_cnt=V_TOT−1. If pending=1 at the start of that cycle:
  - the active timing takes the shadow register values, so a same-cycle field write is not included;
  - pending clears, unless a commit is written in that same cycle, in which case pending stays 1.
- Enable=0: counters are forced to 0 and held, request=0. The pipeline drains to the idle outputs within LAT+1 cycles.
- Enable 0→1: the raster restarts at (0,0), and `frame_start` follows LAT+1 cycles later.
- Enable write and commit are independent; a commit applied while disabled takes effect on re-enable.

## Timing
- Reset values:
  - counters, pending, `cfg_err`, `lcd_request`, `lcd_xpos`, `lcd_ypos`, `lcd_en`, `lcd_rgb`, `frame_start`: 0;
  - `lcd_hs` = !HS_POL, `lcd_vs` = !VS_POL;
  - active and shadow timing = parameters; enable = 1.
- First cycle after `rst` falls: h_cnt=0, v_cnt=0.
- Latency: a coordinate issued at cycle t appears on `lcd_rgb` with `lcd_en`=1 at t+LAT+1. HS/VS/frame_start have the same offset.
- `cfg_err` is asserted in the cycle after the commit strobe. `cfg_pending` rises in the cycle after a valid commit.
- New timing governs h_cnt from the cycle after the boundary; the output pins change LAT+1 cycles later.
- `rst` mid-frame: all of the above reset values apply in the next cycle; the pipeline contents are discarded.

## Test plan
Use small timing parameters, LAT=2, POL=1: H 8/2/2/3 (ACT/FP/SYNC/BP, H_TOT=15), V 4/1/1/2 (V_TOT=8).
- Release reset, `lcd_data`={xpos,ypos} via a 2-stage pipe:
  - first `lcd_request` at cycle 50 (v=3, h=5) with xpos=0, ypos=0;
  - `lcd_en` rises at cycle 53 with rgb=data(0,0);
  - 8 enables per line, 4 lines; frame_start every 120 cycles.
- HS high for cycles 0..1 mod 15 (offset +3); VS high for output cycles 3..17 of each frame.
- Write H_ACT=10, then commit mid-frame: `cfg_pending`=1 until the boundary at cycle 119; the next frame has H_TOT=17 and 10 enables per line.
- Commit with H_ACT=4090 at COORD_W=12: `cfg_err` pulses once, `cfg_pending` stays 0, timing unchanged.
- Commit in the same cycle as a boundary that has a pending commit: the first commit applies, `cfg_pending` stays 1, and the second applies at the next boundary.
- Enable=0 mid-line, then enable=1 after 20 cycles: outputs idle 3 cycles after the disable; raster resumes at (0,0) with `frame_start` 3 cycles after re-enable.
- Assert `rst` during the active area: next cycle all outputs are at reset values, and active timing is back to the parameters.
